stream_packet_arbiter: RTL and testbench
========================================

# stream_packet_arbiter

N-input, packet-atomic round-robin arbiter for the UART packet stream fabric. It sits between any number of packet sources (register control, data return, future status streams) and the single UART packet transmitter. A grant is held from the start-of-packet beat through the end-of-packet beat, so packets are never interleaved. The output is registered for timing, and non-packet-aligned traffic is flushed and flagged.

## Interface
Parameters:
- N, 4, number of requesters; legal range 2..8
- W, 32, beat width; the packed {Source, Destination, Length, Data} payload

Ports:
- ipClk  in  1  clock
- ipReset  in  1  asynchronous, active-high reset
- ipSoP  in  N  per-input start-of-packet flag
- ipEoP  in  N  per-input end-of-packet flag
- ipData  in  N*W  per-input beat; input i occupies bits [i*W +: W]
- ipValid  in  N  per-input beat valid
- opReady  out  N  per-input ready
- opSoP  out  1  output start-of-packet
- opEoP  out  1  output end-of-packet
- opData  out  W  output beat
- opValid  out  1  output valid
- ipReady  in  1  downstream ready
- opGrant  out  N  one-hot current grant; 0 when idle
- opDropped  out  1  one-cycle pulse per flushed non-SoP beat
- opError  out  1  one-cycle pulse when SoP arrives mid-packet on the granted input

## Operation
- Handshake: a beat transfers when valid and ready are both high in the same cycle. Transfers on both sides follow this rule.
- States: IDLE and LOCKED.
- IDLE
  - Requester i is eligible when ipValid[i] & ipSoP[i].
  - The search starts at pointer Ptr and proceeds Ptr, Ptr+1, … modulo N. The first eligible input wins.
  - The winner is registered into opGrant and the state becomes LOCKED on the next edge.
  - Any input with ipValid=1 and ipSoP=0 is flushed: opReady[i]=1 and opDropped=1. Only the lowest such index is flushed per cycle.
- LOCKED
  - opReady[g] = ~opValid | ipReady. All other opReady bits are 0.
  - An accepted beat loads the output register {opSoP, opEoP, opData}, and opValid is set.
  - If the output register drains with no new beat accepted, opValid clears.
  - When the accepted beat has EoP=1:
    - next state is IDLE;
    - Ptr ← (g+1) mod N;
    - opGrant ← 0.
  - An accepted beat with SoP=1, other than the first beat of the grant, is forwarded unchanged and opError pulses.
- A single-beat packet (SoP=EoP=1) enters and leaves LOCKED on one accepted beat.
- Arithmetic: Ptr is $clog2(N) bits and wraps N-1 → 0. It is never equal to or above N.
- Reset (asynchronous; valid at any point, including mid-packet):
  - state IDLE, Ptr=0;
  - opGrant=0, opValid=0, opSoP=0, opEoP=0, opData=0;
  - opDropped=0, opError=0;
  - opReady=0.
  - A partially forwarded packet is abandoned. Downstream is also reset.

## Timing
- Arbitration: 1 cycle. A request seen in IDLE at edge k gives opGrant valid after edge k+1.
- First beat: accepted in cycle k+1 and appears on opValid after edge k+2.
- Streaming: with ipReady held high, 1 beat per cycle with no bubbles inside a packet.
- Packet-to-packet: 1 idle arbitration cycle between packets. This gives an N-input throughput bound of L/(L+1) for L-beat packets.
- Backpressure: ipReady low while opValid=1 holds the output register and forces opReady[g]=0 in the same cycle (combinational path ipReady → opReady).
- Fairness: a continuously requesting input waits at most N-1 packets.
- opDropped and opError are registered pulses, asserted the cycle after the offending transfer.

## Configuration
- STREAM_PACKET_ARBITER_PRIORITY_EN
  - Defined: input 0 has strict priority in IDLE. It wins whenever eligible, regardless of Ptr, and Ptr is not updated after its packets. Other inputs are round-robin among themselves.
  - Undefined: pure round-robin as described above.
  - Packet atomicity is unaffected in both cases.

## Test plan
- Reset mid-packet: input 1 sends SoP plus 2 beats, then ipReset is pulsed → all outputs 0 and opGrant=0. After release, input 1 sends a new SoP packet; it is forwarded complete and opError=0.
- Round-robin: inputs 0..3 each continuously offer 3-beat packets with ipReady=1 → output packet order 0,1,2,3,0,…. Each packet is contiguous and there is exactly 1 idle cycle between packets.
- Backpressure: input 2 sends 5 beats; ipReady toggles 1,0,0,1,… → all 5 beats arrive in order, none lost or duplicated, and opData is stable while opValid=1 & ipReady=0.
- Flush: input 3 offers 2 beats with SoP=0, then a SoP/EoP beat of 0xA5A5A5A5 → opDropped pulses twice, then a single beat 0xA5A5A5A5 is output with SoP=EoP=1.
- Mid-packet SoP: input 0 sends SoP, SoP, EoP → 3 beats are forwarded and opError pulses once.
- With STREAM_PACKET_ARBITER_PRIORITY_EN defined: inputs 0 and 1 both saturate → only input-0 packets are granted until input 0 goes idle, then input 1 is granted.

Source files
------------

// File: rtl/stream_packet_arbiter.sv
// stream_packet_arbiter: N-input packet-atomic round-robin arbiter feeding
// a single registered output stream; stray non-SoP beats are flushed.
//
// Parameters: N requesters (2..8), W beat width.
// Ports:
//   ipClk, ipReset        clock, async active-high reset
//   ipSoP/ipEoP/ipValid   per-input packet flags and valid [N]
//   ipData                per-input beats, input i at [i*W +: W]
//   opReady               per-input ready [N]
//   opSoP/opEoP/opData    registered output beat
//   opValid, ipReady      output handshake
//   opGrant               one-hot grant, 0 when idle
//   opDropped, opError    one-cycle pulses (flushed beat, SoP mid-packet)
// Build option: STREAM_PACKET_ARBITER_PRIORITY_EN gives input 0 strict
// priority in IDLE and leaves the round-robin pointer untouched after it.

module stream_packet_arbiter #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           ipClk,
  input  logic           ipReset,
  input  logic [N-1:0]   ipSoP,
  input  logic [N-1:0]   ipEoP,
  input  logic [N*W-1:0] ipData,
  input  logic [N-1:0]   ipValid,
  output logic [N-1:0]   opReady,
  output logic           opSoP,
  output logic           opEoP,
  output logic [W-1:0]   opData,
  output logic           opValid,
  input  logic           ipReady,
  output logic [N-1:0]   opGrant,
  output logic           opDropped,
  output logic           opError
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gidx;
  logic [N-1:0]  r_grant;
  logic          r_first;
  logic          r_sop;
  logic          r_eop;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          r_dropped;
  logic          r_error;

  logic [N-1:0]  w_elig;
  logic [N-1:0]  w_stray;
  logic          w_win;
  logic [PW-1:0] w_win_idx;
  logic [PW-1:0] w_k;
  logic          w_flush;
  logic [PW-1:0] w_flush_idx;
  logic          w_rdy_g;
  logic          w_acc;
  logic          w_gsop;
  logic          w_geop;
  logic [W-1:0]  w_gdata;
  logic [PW-1:0] w_ptr_nxt;

  function automatic int wrap(input int k);
    return (k >= N) ? k - N : k;
  endfunction

  // Winner search from r_ptr, plus lowest-index stray beat to flush.
  always_comb begin : arb
    w_elig      = ipValid & ipSoP;
    w_stray     = ipValid & ~ipSoP;
    w_win       = 1'b0;
    w_win_idx   = '0;
    w_k         = '0;
    for (int j = 0; j < N; j++) begin
      w_k = PW'(wrap(int'(r_ptr) + j));
      if (!w_win && w_elig[w_k]) begin
        w_win     = 1'b1;
        w_win_idx = w_k;
      end
    end
`ifdef STREAM_PACKET_ARBITER_PRIORITY_EN
    if (w_elig[0]) begin
      w_win     = 1'b1;
      w_win_idx = '0;
    end
`endif
    w_flush     = 1'b0;
    w_flush_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_stray[j]) begin
        w_flush     = 1'b1;
        w_flush_idx = PW'(j);
      end
    end
  end

  assign w_gsop    = ipSoP[r_gidx];
  assign w_geop    = ipEoP[r_gidx];
  assign w_gdata   = ipData[int'(r_gidx) * W +: W];
  assign w_ptr_nxt = (r_gidx == LAST) ? '0 : r_gidx + 1'b1;

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // opReady is held low while reset is asserted, even for stray beats.
  always_comb begin : fsm
    w_next  = r_state;
    opReady = '0;
    w_rdy_g = 1'b0;
    w_acc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_flush && !ipReset) opReady[w_flush_idx] = 1'b1;
        if (w_win) w_next = S_LOCKED;
      end
      S_LOCKED: begin
        w_rdy_g         = (~r_valid | ipReady) & ~ipReset;
        opReady[r_gidx] = w_rdy_g;
        w_acc           = ipValid[r_gidx] & w_rdy_g;
        if (w_acc && w_geop) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_first   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_dropped <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_dropped <= (r_state == S_IDLE) & w_flush;
      r_error   <= w_acc & w_gsop & ~r_first;
      if (r_state == S_IDLE && w_win) begin
        r_grant <= {{(N-1){1'b0}}, 1'b1} << w_win_idx;
        r_gidx  <= w_win_idx;
        r_first <= 1'b1;
      end
      if (w_acc) begin
        r_first <= 1'b0;
        if (w_geop) begin
          r_grant <= '0;
`ifdef STREAM_PACKET_ARBITER_PRIORITY_EN
          if (r_gidx != '0) r_ptr <= w_ptr_nxt;
`else
          r_ptr <= w_ptr_nxt;
`endif
        end
      end
      if (w_acc) begin
        r_valid <= 1'b1;
        r_sop   <= w_gsop;
        r_eop   <= w_geop;
        r_data  <= w_gdata;
      end else if (ipReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign opSoP     = r_sop;
  assign opEoP     = r_eop;
  assign opData    = r_data;
  assign opValid   = r_valid;
  assign opGrant   = r_grant;
  assign opDropped = r_dropped;
  assign opError   = r_error;

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// tb_stream_packet_arbiter: scoreboard bench for stream_packet_arbiter.
// Sources are per-input beat FIFOs; expected output beats are queued.

module tb_stream_packet_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {
    logic         sop;
    logic         eop;
    logic [W-1:0] data;
  } beat_t;

  logic           ipClk = 1'b0;
  logic           ipReset = 1'b1;
  logic [N-1:0]   ipSoP = '0;
  logic [N-1:0]   ipEoP = '0;
  logic [N*W-1:0] ipData = '0;
  logic [N-1:0]   ipValid = '0;
  logic [N-1:0]   opReady;
  logic           opSoP;
  logic           opEoP;
  logic [W-1:0]   opData;
  logic           opValid;
  logic           ipReady = 1'b0;
  logic [N-1:0]   opGrant;
  logic           opDropped;
  logic           opError;

  stream_packet_arbiter #(.N(N), .W(W)) dut (
    .ipClk    (ipClk),
    .ipReset  (ipReset),
    .ipSoP    (ipSoP),
    .ipEoP    (ipEoP),
    .ipData   (ipData),
    .ipValid  (ipValid),
    .opReady  (opReady),
    .opSoP    (opSoP),
    .opEoP    (opEoP),
    .opData   (opData),
    .opValid  (opValid),
    .ipReady  (ipReady),
    .opGrant  (opGrant),
    .opDropped(opDropped),
    .opError  (opError)
  );

  always #5 ipClk = ~ipClk;

  beat_t smem [N][32];
  int    shead [N];
  int    stail [N];
  beat_t exp_q [$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;

  function automatic beat_t mk(input int s, input int p, input int b,
                               input int len);
    beat_t r;
    r.sop  = (b == 0);
    r.eop  = (b == len - 1);
    r.data = {8'(s), 8'(p), 16'(b)};
    return r;
  endfunction

  function automatic void load_pkt(input int s, input int p, input int len);
    for (int b = 0; b < len; b++) begin
      smem[s][stail[s]] = mk(s, p, b, len);
      stail[s]++;
    end
  endfunction

  function automatic void expect_pkt(input int s, input int p, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back(mk(s, p, b, len));
  endfunction

  function automatic void put(input int s, input logic sop, input logic eop,
                              input logic [W-1:0] d);
    smem[s][stail[s]] = '{sop: sop, eop: eop, data: d};
    stail[s]++;
  endfunction

  function automatic logic done();
    logic r;
    r = (exp_q.size() == 0);
    for (int i = 0; i < N; i++) if (shead[i] != stail[i]) r = 1'b0;
    return r;
  endfunction

  function automatic void clear_all();
    for (int i = 0; i < N; i++) begin
      shead[i] = 0;
      stail[i] = 0;
    end
    exp_q.delete();
    ipValid = '0;
    ipSoP   = '0;
    ipEoP   = '0;
    ipData  = '0;
  endfunction

  // Drive FIFO heads, sample at negedge, pop accepted beats after the edge.
  task automatic cycle(output logic xf, output beat_t bt, output logic vld,
                       output logic drp, output logic err,
                       output logic [N-1:0] rdy);
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      if (shead[i] < stail[i]) begin
        ipValid[i]          = 1'b1;
        ipSoP[i]            = smem[i][shead[i]].sop;
        ipEoP[i]            = smem[i][shead[i]].eop;
        ipData[i*W +: W]    = smem[i][shead[i]].data;
      end else begin
        ipValid[i]          = 1'b0;
        ipSoP[i]            = 1'b0;
        ipEoP[i]            = 1'b0;
        ipData[i*W +: W]    = '0;
      end
    end
    @(negedge ipClk);
    vld = opValid;
    xf  = opValid & ipReady;
    bt  = {opSoP, opEoP, opData};
    drp = opDropped;
    err = opError;
    rdy = opReady;
    acc = ipValid & opReady;
    @(posedge ipClk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) shead[i]++;
    cyc++;
  endtask

  task automatic do_reset();
    ipReset = 1'b1;
    clear_all();
    ipReady = 1'b0;
    @(posedge ipClk);
    #1;
    ipReset = 1'b0;
  endtask

  task automatic test_reset();
    logic xf, vld, drp, err;
    beat_t bt;
    logic [N-1:0] rdy;
    clear_all();
    ipReset = 1'b1;
    @(negedge ipClk);
    n_checks++;
    if ({opGrant, opValid, opSoP, opEoP, opData, opDropped, opError,
         opReady} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b valid=%b data=%h rdy=%b, want 0",
               opGrant, opValid, opData, opReady);
    end
    @(posedge ipClk);
    #1;
    ipReset = 1'b0;
    ipReady = 1'b1;
    repeat (3) cycle(xf, bt, vld, drp, err, rdy);
    n_checks++;
    if ({opGrant, opValid, drp, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: grant=%b valid=%b drop=%b err=%b, want 0",
               opGrant, opValid, drp, err);
    end
  endtask

  task automatic test_reset_mid();
    logic xf, vld, drp, err;
    beat_t bt, e;
    logic [N-1:0] rdy;
    int errs;
    do_reset();
    ipReady = 1'b1;
    load_pkt(1, 0, 6);
    expect_pkt(1, 0, 6);
    for (int c = 0; c < 20 && shead[1] < 3; c++) begin
      cycle(xf, bt, vld, drp, err, rdy);
      if (xf) begin
        n_checks++;
        e = exp_q.pop_front();
        if (bt !== e) begin
          n_fail++;
          $display("FAIL mid_prefix_beat: got %h, want %h", bt, e);
        end
      end
    end
    n_checks++;
    if (shead[1] != 3) begin
      n_fail++;
      $display("FAIL mid_prefix_timeout: accepted %0d, want 3", shead[1]);
    end
    ipReset = 1'b1;
    @(negedge ipClk);
    n_checks++;
    if ({opGrant, opValid, opSoP, opEoP, opData, opDropped, opError,
         opReady} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: grant=%b valid=%b data=%h rdy=%b, want 0",
               opGrant, opValid, opData, opReady);
    end
    clear_all();
    @(posedge ipClk);
    #1;
    ipReset = 1'b0;
    load_pkt(1, 1, 3);
    expect_pkt(1, 1, 3);
    errs = 0;
    for (int c = 0; c < 40 && !done(); c++) begin
      cycle(xf, bt, vld, drp, err, rdy);
      if (err) errs++;
      if (xf) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mid_after_beat: got %h, want no beat", bt);
        end else begin
          e = exp_q.pop_front();
          if (bt !== e) begin
            n_fail++;
            $display("FAIL mid_after_beat: got %h, want %h", bt, e);
          end
        end
      end
    end
    n_checks++;
    if (!done() || errs != 0) begin
      n_fail++;
      $display("FAIL mid_after_done: left=%0d errors=%0d, want 0 0",
               exp_q.size(), errs);
    end
  endtask

  task automatic test_round_robin();
    logic xf, vld, drp, err;
    beat_t bt, e;
    logic [N-1:0] rdy;
    int last_xf, last_eop;
    logic have_eop;
    do_reset();
    ipReady = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < N; s++) begin
        load_pkt(s, p, 3);
        expect_pkt(s, p, 3);
      end
    have_eop = 1'b0;
    last_xf  = 0;
    last_eop = 0;
    for (int c = 0; c < 100 && !done(); c++) begin
      cycle(xf, bt, vld, drp, err, rdy);
      if (xf) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rr_beat: got %h, want no beat", bt);
        end else begin
          e = exp_q.pop_front();
          if (bt !== e) begin
            n_fail++;
            $display("FAIL rr_beat: got %h, want %h", bt, e);
          end
        end
        if (bt.sop && have_eop) begin
          n_checks++;
          if (cyc - last_eop != 2) begin
            n_fail++;
            $display("FAIL rr_gap: got %0d cycles, want 2", cyc - last_eop);
          end
        end
        if (!bt.sop) begin
          n_checks++;
          if (cyc - last_xf != 1) begin
            n_fail++;
            $display("FAIL rr_bubble: got %0d cycles, want 1", cyc - last_xf);
          end
        end
        last_xf = cyc;
        if (bt.eop) begin
          last_eop = cyc;
          have_eop = 1'b1;
        end
      end
    end
    n_checks++;
    if (!done()) begin
      n_fail++;
      $display("FAIL rr_timeout: %0d beats left, want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic xf, vld, drp, err;
    beat_t bt, e;
    logic [N-1:0] rdy;
    logic pv, pr;
    logic [W-1:0] pd;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    load_pkt(2, 0, 5);
    expect_pkt(2, 0, 5);
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    for (int c = 0; c < 60 && !done(); c++) begin
      ipReady = pat[c % 4];
      cycle(xf, bt, vld, drp, err, rdy);
      if (pv && !pr && vld) begin
        n_checks++;
        if (bt.data !== pd) begin
          n_fail++;
          $display("FAIL bp_stable: got %h, want %h", bt.data, pd);
        end
      end
      if (vld && !ipReady) begin
        n_checks++;
        if (rdy[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready: got %b, want 0", rdy[2]);
        end
      end
      if (xf) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_beat: got %h, want no beat", bt);
        end else begin
          e = exp_q.pop_front();
          if (bt !== e) begin
            n_fail++;
            $display("FAIL bp_beat: got %h, want %h", bt, e);
          end
        end
      end
      pv = vld;
      pr = ipReady;
      pd = bt.data;
    end
    n_checks++;
    if (!done()) begin
      n_fail++;
      $display("FAIL bp_timeout: %0d beats left, want 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    logic xf, vld, drp, err;
    beat_t bt, e;
    logic [N-1:0] rdy;
    int drops;
    do_reset();
    ipReady = 1'b1;
    put(3, 1'b0, 1'b0, 32'h1111_0001);
    put(3, 1'b0, 1'b0, 32'h1111_0002);
    put(3, 1'b1, 1'b1, 32'hA5A5_A5A5);
    exp_q.push_back('{sop: 1'b1, eop: 1'b1, data: 32'hA5A5_A5A5});
    drops = 0;
    for (int c = 0; c < 40 && !done(); c++) begin
      cycle(xf, bt, vld, drp, err, rdy);
      if (drp) drops++;
      if (xf) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL flush_beat: got %h, want no beat", bt);
        end else begin
          e = exp_q.pop_front();
          if (bt !== e) begin
            n_fail++;
            $display("FAIL flush_beat: got %h, want %h", bt, e);
          end
        end
      end
    end
    n_checks++;
    if (!done() || drops != 2) begin
      n_fail++;
      $display("FAIL flush_drops: got %0d drops, %0d left, want 2 0",
               drops, exp_q.size());
    end
  endtask

  task automatic test_mid_sop();
    logic xf, vld, drp, err;
    beat_t bt, e;
    logic [N-1:0] rdy;
    int errs;
    do_reset();
    ipReady = 1'b1;
    put(0, 1'b1, 1'b0, 32'h0C00_0000);
    put(0, 1'b1, 1'b0, 32'h0C00_0001);
    put(0, 1'b0, 1'b1, 32'h0C00_0002);
    for (int i = 0; i < 3; i++) exp_q.push_back(smem[0][i]);
    errs = 0;
    for (int c = 0; c < 40 && !done(); c++) begin
      cycle(xf, bt, vld, drp, err, rdy);
      if (err) errs++;
      if (xf) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL msop_beat: got %h, want no beat", bt);
        end else begin
          e = exp_q.pop_front();
          if (bt !== e) begin
            n_fail++;
            $display("FAIL msop_beat: got %h, want %h", bt, e);
          end
        end
      end
    end
    n_checks++;
    if (!done() || errs != 1) begin
      n_fail++;
      $display("FAIL msop_error: got %0d pulses, %0d left, want 1 0",
               errs, exp_q.size());
    end
  endtask

  task automatic test_priority();
    logic xf, vld, drp, err;
    beat_t bt, e;
    logic [N-1:0] rdy;
    do_reset();
    ipReady = 1'b1;
    for (int p = 0; p < 3; p++) load_pkt(0, p, 2);
    for (int p = 0; p < 2; p++) load_pkt(1, p, 2);
`ifdef STREAM_PACKET_ARBITER_PRIORITY_EN
    for (int p = 0; p < 3; p++) expect_pkt(0, p, 2);
    for (int p = 0; p < 2; p++) expect_pkt(1, p, 2);
`else
    expect_pkt(0, 0, 2);
    expect_pkt(1, 0, 2);
    expect_pkt(0, 1, 2);
    expect_pkt(1, 1, 2);
    expect_pkt(0, 2, 2);
`endif
    for (int c = 0; c < 60 && !done(); c++) begin
      cycle(xf, bt, vld, drp, err, rdy);
      if (xf) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL prio_beat: got %h, want no beat", bt);
        end else begin
          e = exp_q.pop_front();
          if (bt !== e) begin
            n_fail++;
            $display("FAIL prio_beat: got %h, want %h", bt, e);
          end
        end
      end
    end
    n_checks++;
    if (!done()) begin
      n_fail++;
      $display("FAIL prio_timeout: %0d beats left, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_mid_sop();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
